// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC stage: FSM encoding, jump constant, opcodes.
package fetch_pc_unit_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_WAIT    = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RESOLVE = 3'd4
   } fetch_state_t;

   // ALU jump output value that means "taken"
   localparam logic [7:0] JUMP_TAKEN_C = 8'hFF;

   // Upper-nibble opcodes of control-flow instructions
   localparam logic [3:0] OP_JMP = 4'h8;
   localparam logic [3:0] OP_JAL = 4'h9;
   localparam logic [3:0] OP_BEQ = 4'hA;
   localparam logic [3:0] OP_BNE = 4'hB;

endpackage : fetch_pc_unit_pkg

// File: rtl/fetch_pc_unit_pc_next_calc.sv
// Combinational next-PC / link-PC calculation. All arithmetic wraps mod 256.
module fetch_pc_unit_pc_next_calc
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [7:0] JUMP_TAKEN = JUMP_TAKEN_C
)(
   input  logic [7:0] i_pc,
   input  logic [7:0] i_jump,
   input  logic [7:0] i_offset,
   output logic [7:0] o_next_pc,
   output logic [7:0] o_link_pc
);

   // Sequential successor, and offset applied on top of it for a taken jump
   always_comb begin
      o_link_pc = i_pc + 8'd1;
      o_next_pc = o_link_pc;
      if (i_jump == JUMP_TAKEN) begin
         o_next_pc = o_link_pc + i_offset;
      end else begin
         o_next_pc = o_link_pc;
      end
   end

endmodule : fetch_pc_unit_pc_next_calc

// File: rtl/fetch_pc_unit.sv
// Program counter and single-issue instruction fetch stage feeding the 8-bit ALU.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [7:0]  RESET_PC    = 8'h00,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter logic [7:0]  JUMP_TAKEN  = JUMP_TAKEN_C
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        halt,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_valid,
   input  logic [7:0]  imem_data,
   output logic [7:0]  instr_out,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [7:0]  pc_out,
   input  logic        exec_done,
   input  logic [7:0]  jump_in,
   input  logic [7:0]  offset_in,
   output logic [7:0]  link_pc,
   output logic        busy,
   output logic        fetch_err,
   output logic [15:0] retired
);

   // Last counter value seen in WAIT before the timeout fires
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;

   logic [7:0]  r_pc;
   logic [7:0]  r_instr;
   logic [7:0]  r_cnt;
   logic        r_fetch_err;
   logic [15:0] r_retired;

   logic [7:0]  w_next_pc;
   logic [7:0]  w_link_pc;
   logic        w_load_instr;
   logic        w_cnt_clr;
   logic        w_cnt_inc;
   logic        w_set_err;
   logic        w_retire;

   fetch_pc_unit_pc_next_calc #(
      .JUMP_TAKEN (JUMP_TAKEN)
   ) u_pc_next_calc (
      .i_pc      (r_pc),
      .i_jump    (jump_in),
      .i_offset  (offset_in),
      .o_next_pc (w_next_pc),
      .o_link_pc (w_link_pc)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state and datapath control strobes
   always_comb begin
      w_state_nxt  = r_state;
      w_load_instr = 1'b0;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_set_err    = 1'b0;
      w_retire     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A latched fetch error locks the stage until reset
            if (start && !r_fetch_err) begin
               w_state_nxt = ST_REQ;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REQ: begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // Data arriving on the timeout cycle still wins
            if (imem_valid) begin
               w_load_instr = 1'b1;
               w_state_nxt  = ST_HOLD;
            end else if (r_cnt >= TIMEOUT_LAST) begin
               w_set_err    = 1'b1;
               w_state_nxt  = ST_IDLE;
            end else begin
               w_cnt_inc    = 1'b1;
               w_state_nxt  = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (instr_ready) begin
               w_state_nxt = ST_RESOLVE;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_RESOLVE: begin
            if (exec_done) begin
               w_retire = 1'b1;
               if (halt) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_REQ;
               end
            end else begin
               w_state_nxt = ST_RESOLVE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath registers: PC, instruction latch, timeout counter, error flag, retire count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= RESET_PC;
         r_instr     <= 8'h00;
         r_cnt       <= 8'h00;
         r_fetch_err <= 1'b0;
         r_retired   <= 16'h0000;
      end else begin
         if (w_load_instr) begin
            r_instr <= imem_data;
         end else begin
            r_instr <= r_instr;
         end

         if (w_cnt_clr) begin
            r_cnt <= 8'h00;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 8'd1;
         end else begin
            r_cnt <= r_cnt;
         end

         if (w_set_err) begin
            r_fetch_err <= 1'b1;
         end else begin
            r_fetch_err <= r_fetch_err;
         end

         // PC redirect coincides with the RESOLVE exit edge
         if (w_retire) begin
            r_pc <= w_next_pc;
            if (r_retired != 16'hFFFF) begin
               r_retired <= r_retired + 16'd1;
            end else begin
               r_retired <= r_retired;
            end
         end else begin
            r_pc      <= r_pc;
            r_retired <= r_retired;
         end
      end
   end

   assign imem_req    = (r_state == ST_REQ);
   assign imem_addr   = r_pc;
   assign instr_out   = r_instr;
   assign instr_valid = (r_state == ST_HOLD);
   assign pc_out      = r_pc;
   assign link_pc     = w_link_pc;
   assign busy        = (r_state != ST_IDLE);
   assign fetch_err   = r_fetch_err;
   assign retired     = r_retired;

endmodule : fetch_pc_unit

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit.
module tb_fetch_pc_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        halt;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_valid;
   logic [7:0]  imem_data;
   logic [7:0]  instr_out;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  pc_out;
   logic        exec_done;
   logic [7:0]  jump_in;
   logic [7:0]  offset_in;
   logic [7:0]  link_pc;
   logic        busy;
   logic        fetch_err;
   logic [15:0] retired;

   int n_cmp;
   int n_err;

   fetch_pc_unit #(
      .RESET_PC    (8'h00),
      .MEM_TIMEOUT (15),
      .JUMP_TAKEN  (8'hFF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .halt        (halt),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_valid  (imem_valid),
      .imem_data   (imem_data),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc_out      (pc_out),
      .exec_done   (exec_done),
      .jump_in     (jump_in),
      .offset_in   (offset_in),
      .link_pc     (link_pc),
      .busy        (busy),
      .fetch_err   (fetch_err),
      .retired     (retired)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full instruction with zero-latency memory; entered with the DUT in REQ
   task automatic run_instr(input logic [7:0] data, input logic [7:0] jmp,
                            input logic [7:0] off, input logic hlt,
                            input logic [7:0] exp_pc, input logic [7:0] exp_next);
      chk("req_pulse", {15'd0, imem_req}, 16'd1);
      chk("req_addr", {8'd0, imem_addr}, {8'd0, exp_pc});
      step();                                  // WAIT
      imem_valid = 1'b1;
      imem_data  = data;
      step();                                  // HOLD
      imem_valid = 1'b0;
      chk("hold_valid", {15'd0, instr_valid}, 16'd1);
      chk("hold_instr", {8'd0, instr_out}, {8'd0, data});
      chk("hold_pc", {8'd0, pc_out}, {8'd0, exp_pc});
      chk("hold_link", {8'd0, link_pc}, {8'd0, exp_pc + 8'd1});
      instr_ready = 1'b1;
      step();                                  // RESOLVE
      instr_ready = 1'b0;
      chk("resolve_valid", {15'd0, instr_valid}, 16'd0);
      exec_done = 1'b1;
      jump_in   = jmp;
      offset_in = off;
      halt      = hlt;
      step();                                  // REQ or IDLE
      exec_done = 1'b0;
      jump_in   = 8'h00;
      offset_in = 8'h00;
      halt      = 1'b0;
      chk("next_pc", {8'd0, pc_out}, {8'd0, exp_next});
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      halt        = 1'b0;
      imem_valid  = 1'b0;
      imem_data   = 8'h00;
      instr_ready = 1'b0;
      exec_done   = 1'b0;
      jump_in     = 8'h00;
      offset_in   = 8'h00;

      // Reset state
      step();
      step();
      chk("rst_pc", {8'd0, pc_out}, 16'h0000);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_instr", {8'd0, instr_out}, 16'h0000);
      chk("rst_req", {15'd0, imem_req}, 16'd0);
      chk("rst_ivalid", {15'd0, instr_valid}, 16'd0);
      chk("rst_err", {15'd0, fetch_err}, 16'd0);
      chk("rst_retired", retired, 16'h0000);
      rst_n = 1'b1;
      step();

      // 1. Straight-line: memory answers one cycle into WAIT
      start = 1'b1;
      step();                                  // REQ
      start = 1'b0;
      chk("t1_busy", {15'd0, busy}, 16'd1);
      run_instr(8'h12, 8'h00, 8'h33, 1'b0, 8'h00, 8'h01);
      run_instr(8'h12, 8'h00, 8'h00, 1'b0, 8'h01, 8'h02);
      chk("t1_retired", retired, 16'd2);

      // Advance to 05; a non-FF jump_in is not taken
      run_instr(8'h21, 8'h00, 8'h00, 1'b0, 8'h02, 8'h03);
      run_instr(8'h22, 8'h7F, 8'h40, 1'b0, 8'h03, 8'h04);
      run_instr(8'h23, 8'hFE, 8'h10, 1'b0, 8'h04, 8'h05);

      // 2. Taken forward jump: 05 + 1 + 0A = 10
      run_instr(8'h80, 8'hFF, 8'h0A, 1'b0, 8'h05, 8'h10);

      // 3. Backward jumps: 10 -> 02 (offset F1), 02 -> FF (offset FC), FF -> 00 wrap
      run_instr(8'h81, 8'hFF, 8'hF1, 1'b0, 8'h10, 8'h02);
      run_instr(8'hA0, 8'hFF, 8'hFC, 1'b0, 8'h02, 8'hFF);
      run_instr(8'h01, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00);
      chk("t3_retired", retired, 16'd9);

      // 5. Back-pressure then halt
      step();                                  // WAIT
      imem_valid = 1'b1;
      imem_data  = 8'h5A;
      step();                                  // HOLD
      imem_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", {15'd0, instr_valid}, 16'd1);
         chk("bp_instr", {8'd0, instr_out}, 16'h005A);
         chk("bp_pc", {8'd0, pc_out}, 16'h0000);
      end
      instr_ready = 1'b1;
      step();                                  // RESOLVE
      instr_ready = 1'b0;
      exec_done = 1'b1;
      halt      = 1'b1;
      jump_in   = 8'h00;
      step();                                  // IDLE
      exec_done = 1'b0;
      halt      = 1'b0;
      chk("halt_busy", {15'd0, busy}, 16'd0);
      chk("halt_pc", {8'd0, pc_out}, 16'h0001);
      chk("halt_retired", retired, 16'd10);
      // exec_done outside RESOLVE has no effect
      exec_done = 1'b1;
      jump_in   = 8'hFF;
      offset_in = 8'h40;
      step();
      exec_done = 1'b0;
      jump_in   = 8'h00;
      offset_in = 8'h00;
      chk("idle_exec_pc", {8'd0, pc_out}, 16'h0001);
      chk("idle_exec_ret", retired, 16'd10);

      // Data on the last WAIT cycle beats the timeout
      start = 1'b1;
      step();                                  // REQ
      start = 1'b0;
      step();                                  // WAIT cycle 1
      for (int i = 0; i < 14; i++) begin
         step();
      end
      chk("edge_still_wait", {15'd0, busy}, 16'd1);
      imem_valid = 1'b1;
      imem_data  = 8'hC3;
      step();
      imem_valid = 1'b0;
      chk("edge_no_err", {15'd0, fetch_err}, 16'd0);
      chk("edge_valid", {15'd0, instr_valid}, 16'd1);
      chk("edge_instr", {8'd0, instr_out}, 16'h00C3);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      exec_done = 1'b1;
      halt      = 1'b1;
      step();
      exec_done = 1'b0;
      halt      = 1'b0;
      chk("edge_pc", {8'd0, pc_out}, 16'h0002);

      // 4. Timeout: error and IDLE exactly 15 cycles after entering WAIT
      start = 1'b1;
      step();                                  // REQ
      start = 1'b0;
      step();                                  // entered WAIT
      for (int i = 0; i < 14; i++) begin
         step();
         chk("to_busy", {15'd0, busy}, 16'd1);
         chk("to_noerr", {15'd0, fetch_err}, 16'd0);
      end
      step();
      chk("to_err", {15'd0, fetch_err}, 16'd1);
      chk("to_idle", {15'd0, busy}, 16'd0);
      chk("to_pc", {8'd0, pc_out}, 16'h0002);
      start = 1'b1;
      step();
      chk("to_start_req", {15'd0, imem_req}, 16'd0);
      step();
      start = 1'b0;
      chk("to_start_busy", {15'd0, busy}, 16'd0);

      // 6. Reset clears the error; then reset mid-fetch
      rst_n = 1'b0;
      #1;
      chk("r6_err", {15'd0, fetch_err}, 16'd0);
      chk("r6_pc", {8'd0, pc_out}, 16'h0000);
      step();
      rst_n = 1'b1;
      step();
      start = 1'b1;
      step();                                  // REQ
      start = 1'b0;
      run_instr(8'h77, 8'h00, 8'h00, 1'b0, 8'h00, 8'h01);
      step();                                  // WAIT
      chk("r6_wait_busy", {15'd0, busy}, 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("r6_async_busy", {15'd0, busy}, 16'd0);
      chk("r6_async_pc", {8'd0, pc_out}, 16'h0000);
      chk("r6_async_instr", {8'd0, instr_out}, 16'h0000);
      chk("r6_async_ret", retired, 16'h0000);
      chk("r6_async_req", {15'd0, imem_req}, 16'd0);
      step();
      imem_valid = 1'b1;
      imem_data  = 8'h99;
      rst_n      = 1'b1;
      step();
      step();
      imem_valid = 1'b0;
      chk("r6_stale_valid", {15'd0, instr_valid}, 16'd0);
      chk("r6_stale_busy", {15'd0, busy}, 16'd0);
      chk("r6_stale_instr", {8'd0, instr_out}, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_fetch_pc_unit

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and instruction-fetch stage directly upstream of the 8-bit ALU.
- Holds the 8-bit PC and fetches one instruction byte per step from instruction memory over a req/valid handshake.
- Presents the instruction and PC to the ALU, then waits for the ALU's clocked result and redirects the PC on taken jumps/branches.
- Single-issue: one instruction in flight; no overlap between fetch and execute.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- MEM_TIMEOUT, 15, maximum cycles spent in WAIT before a fetch error is flagged (range 1..255).
- JUMP_TAKEN, 8'hFF, jump_in encoding that means taken.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin fetching from the current PC; honoured in IDLE only.
- halt  in  1  stop after the current instruction retires; level, sampled in RESOLVE.
- imem_req  out  1  fetch request, one-cycle pulse.
- imem_addr  out  8  fetch address, equal to pc_out.
- imem_valid  in  1  imem_data valid; ignored outside WAIT.
- imem_data  in  8  fetched instruction byte.
- instr_out  out  8  instruction to the ALU.
- instr_valid  out  1  instr_out/pc_out valid for the ALU.
- instr_ready  in  1  ALU/decode accepts the instruction.
- pc_out  out  8  PC of the instruction being presented.
- exec_done  in  1  ALU result (jump_in/offset_in) valid this cycle.
- jump_in  in  8  ALU jump output.
- offset_in  in  8  ALU out; for jumps this is target - pc - 1 (mod 256).
- link_pc  out  8  pc_out + 1, for jump-and-link writeback.
- busy  out  1  high in every state except IDLE.
- fetch_err  out  1  sticky; set on memory timeout.
- retired  out  16  count of retired instructions; saturates at 16'hFFFF.

Behaviour:
Reset (async, rst_n low):
- State IDLE; pc = RESET_PC.
- instr_out = 0; all strobes 0; fetch_err = 0; retired = 0.
- Reset asserted mid-operation aborts any pending fetch. Any late imem_valid after release is ignored, because the block is in IDLE.

FSM states: IDLE, REQ, WAIT, HOLD, RESOLVE.
- IDLE: start=1 -> REQ. start is ignored while fetch_err=1.
- REQ: imem_req=1 for exactly this cycle, imem_addr=pc. Next state is WAIT; the timeout counter clears.
- WAIT:
  - imem_valid=1: latch imem_data into instr_out -> HOLD.
  - Otherwise the counter increments. When it reaches MEM_TIMEOUT: fetch_err<=1 -> IDLE, pc unchanged.
  - imem_valid in the same cycle as the timeout: data wins, no error.
- HOLD: instr_valid=1; instr_out and pc_out are stable. When instr_ready=1 -> RESOLVE; instr_valid drops the next cycle.
- RESOLVE: instr_valid=0. Waits indefinitely for exec_done. When exec_done=1:
  - Next PC: if jump_in==JUMP_TAKEN, pc <= pc + 1 + offset_in; otherwise pc <= pc + 1.
  - retired increments.
  - Next state: halt=1 -> IDLE; otherwise REQ.
- exec_done outside RESOLVE is ignored.

Arithmetic:
- All PC arithmetic is 8-bit modulo 256. 8'hFF + 1 wraps to 8'h00 silently.
- jump_in values other than JUMP_TAKEN count as not taken.
- The PC update and the state change happen on the same edge.

Outputs:
- link_pc is combinational, pc + 1 (mod 256).
- imem_addr is combinational and equals pc.

Minimum loop, no stalls: REQ, WAIT, HOLD, RESOLVE = 4 cycles per instruction with zero-latency memory and ALU.

Decomposition:
- Shared package: FSM state encoding (3-bit), JUMP_TAKEN constant, 4-bit opcode constants for jump/JAL/BEQ/BNE (for the bench and for decode).
- One natural sub-module: pc_next_calc. It is combinational and computes next_pc and link_pc from pc, jump_in and offset_in.

Test Plan:
1. Straight-line: reset, start; memory returns 8'h12 after 1 cycle; ALU gives jump_in=0 -> pc_out goes 00, then 01, then 02. instr_out=8'h12, retired=2 after two exec_done pulses.
2. Taken jump: pc=8'h05, exec_done with jump_in=8'hFF and offset_in=8'h0A -> next imem_addr=8'h10; link_pc was 8'h06 during HOLD.
3. Backward jump with wrap: pc=8'h02 and offset_in=8'hFC (-4) -> next pc=8'hFF. Then a not-taken instruction -> pc=8'h00.
4. Memory timeout: MEM_TIMEOUT=15, imem_valid never asserted -> fetch_err=1 and state IDLE exactly 15 cycles after entering WAIT. A following start is ignored until reset.
5. Back-pressure and halt: instr_ready held low 5 cycles -> instr_valid stays high with a stable instr_out. Then halt=1 at exec_done -> IDLE, busy=0, pc advanced by one.
6. Reset mid-fetch: rst_n low during WAIT -> outputs are immediately at reset values. A stale imem_valid after release produces no instr_valid.
